// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory address/data and the instr handshake to decode.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage: addresses instruction memory, registers the
// returned word for decode, and handles stall, branch redirect, PC wrap and HALT.
module fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                MEM_DEPTH  = 128,
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [DATA_W-1:0] HALT_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_branch_valid,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_halted,
    fetch_unit_if.master      bus
);

    // MEM_DEPTH is a power of two, so modulo is a mask
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr_p1;
    logic [ADDR_W-1:0] r_instr_pc_p1;
    logic              r_vld_p1;
    logic              r_halted;
    logic              w_slot_free;
    logic              w_is_halt;

    function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] a);
        return a & PC_MASK;
    endfunction

    assign w_slot_free   = !r_vld_p1 || bus.instr_ready;
    assign w_is_halt     = (bus.imem_data == HALT_INSTR);

    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr_p1;
    assign bus.instr_pc    = r_instr_pc_p1;
    assign bus.instr_valid = r_vld_p1;
    assign o_halted        = r_halted;

    // Fetch FSM: reset, then branch redirect, then per-state capture/stall/drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr_p1    <= '0;
            r_instr_pc_p1 <= '0;
            r_vld_p1      <= 1'b0;
            r_halted      <= 1'b0;
        end else if (i_branch_valid) begin
            // Wrong-path flush; a handshake in this cycle still counts as done
            r_pc     <= wrap_pc(i_branch_target);
            r_vld_p1 <= 1'b0;
            if (r_state == HALT) begin
                r_state  <= FETCH;
                r_halted <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_en) r_state <= FETCH;
                    if (bus.instr_ready) r_vld_p1 <= 1'b0;
                end
                FETCH: begin
                    if (!i_en) begin
                        r_state <= IDLE;
                        if (bus.instr_ready) r_vld_p1 <= 1'b0;
                    end else if (w_slot_free) begin
                        // Stage boundary: memory word -> decode output register
                        r_instr_p1    <= bus.imem_data;
                        r_instr_pc_p1 <= r_pc;
                        r_vld_p1      <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= wrap_pc(r_pc + ADDR_W'(1));
                        end
                    end
                end
                HALT: begin
                    if (bus.instr_ready) r_vld_p1 <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory model answers
// imem_addr combinationally; each task drives one scenario and checks inline.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        halted;
    logic [15:0] mem [128];

    int n_vec = 0;
    int n_err = 0;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (en),
        .i_branch_valid  (branch_valid),
        .i_branch_target (branch_target),
        .o_halted        (halted),
        .bus             (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[6:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; branch_valid = 1'b0; branch_target = '0;
        bus.instr_ready = 1'b0;
        step(); step();
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h, want 0/0000/0000",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        n_vec++;
        if (halted !== 1'b0 || bus.imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_pc: halted=%b addr=%h, want 0/0000", halted, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        step();
        en = 1'b1; bus.instr_ready = 1'b1;
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_edge1: valid=%b, want 0", bus.instr_valid);
        end
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0001 || bus.instr_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL stream_0: valid=%b instr=%h pc=%h, want 1/0001/0000",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0100 || bus.instr_pc !== 16'h0001) begin
            n_err++;
            $display("FAIL stream_1: valid=%b instr=%h pc=%h, want 1/0100/0001",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0100 ||
                bus.instr_pc !== 16'h0001 || bus.imem_addr !== 16'h0002) begin
                n_err++;
                $display("FAIL stall_%0d: valid=%b instr=%h pc=%h addr=%h, want 1/0100/0001/0002",
                         i, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr);
            end
        end
        bus.instr_ready = 1'b1;
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1590 || bus.instr_pc !== 16'h0002) begin
            n_err++;
            $display("FAIL stall_release: valid=%b instr=%h pc=%h, want 1/1590/0002",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_branch();
        branch_valid = 1'b1; branch_target = 16'h0005;
        step();
        branch_valid = 1'b0;
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0005) begin
            n_err++;
            $display("FAIL branch_flush: valid=%b addr=%h, want 0/0005", bus.instr_valid, bus.imem_addr);
        end
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h4400 || bus.instr_pc !== 16'h0005) begin
            n_err++;
            $display("FAIL branch_target_fetch: valid=%b instr=%h pc=%h, want 1/4400/0005",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        branch_valid = 1'b1; branch_target = 16'h007F;
        step();
        branch_valid = 1'b0;
        n_vec++;
        if (bus.imem_addr !== 16'h007F) begin
            n_err++;
            $display("FAIL wrap_branch: addr=%h, want 007f", bus.imem_addr);
        end
        step();
        n_vec++;
        if (bus.instr !== 16'h1231 || bus.instr_pc !== 16'h007F || bus.imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_last: instr=%h pc=%h addr=%h, want 1231/007f/0000",
                     bus.instr, bus.instr_pc, bus.imem_addr);
        end
        step();
        n_vec++;
        if (bus.instr !== 16'h0001 || bus.instr_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_first: instr=%h pc=%h, want 0001/0000", bus.instr, bus.instr_pc);
        end
        branch_valid = 1'b1; branch_target = 16'h0083;
        step();
        branch_valid = 1'b0;
        n_vec++;
        if (bus.imem_addr !== 16'h0003 || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_target_mod: addr=%h valid=%b, want 0003/0", bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_halt();
        mem[3] = 16'hFFFF;
        step();
        n_vec++;
        if (bus.instr !== 16'hFFFF || bus.instr_pc !== 16'h0003 || bus.instr_valid !== 1'b1 ||
            halted !== 1'b1 || bus.imem_addr !== 16'h0003) begin
            n_err++;
            $display("FAIL halt_capture: instr=%h pc=%h valid=%b halted=%b addr=%h, want ffff/0003/1/1/0003",
                     bus.instr, bus.instr_pc, bus.instr_valid, halted, bus.imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (bus.instr_valid !== 1'b0 || halted !== 1'b1 || bus.imem_addr !== 16'h0003) begin
                n_err++;
                $display("FAIL halt_hold_%0d: valid=%b halted=%b addr=%h, want 0/1/0003",
                         i, bus.instr_valid, halted, bus.imem_addr);
            end
        end
        branch_valid = 1'b1; branch_target = 16'h0000;
        step();
        branch_valid = 1'b0;
        n_vec++;
        if (halted !== 1'b0 || bus.imem_addr !== 16'h0000 || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_exit: halted=%b addr=%h valid=%b, want 0/0000/0",
                     halted, bus.imem_addr, bus.instr_valid);
        end
        step();
        n_vec++;
        if (bus.instr !== 16'h0001 || bus.instr_pc !== 16'h0000 || bus.instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL halt_refetch: instr=%h pc=%h valid=%b, want 0001/0000/1",
                     bus.instr, bus.instr_pc, bus.instr_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bus.instr_ready = 1'b0;
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0001) begin
            n_err++;
            $display("FAIL mid_pre: valid=%b instr=%h, want 1/0001", bus.instr_valid, bus.instr);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000 ||
            halted !== 1'b0 || bus.imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b instr=%h pc=%h halted=%b addr=%h, want all zero",
                     bus.instr_valid, bus.instr, bus.instr_pc, halted, bus.imem_addr);
        end
        rst = 1'b1; en = 1'b0; bus.instr_ready = 1'b1;
        step(); step();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_idle: valid=%b, want 0", bus.instr_valid);
        end
        en = 1'b1;
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_restart_edge1: valid=%b, want 0", bus.instr_valid);
        end
        step();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h0001 || bus.instr_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_restart: valid=%b instr=%h pc=%h, want 1/0001/0000",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]   = 16'h0001;
        mem[1]   = 16'h0100;
        mem[2]   = 16'h1590;
        mem[3]   = 16'h2222;
        mem[5]   = 16'h4400;
        mem[127] = 16'h1231;

        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_midstream();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
